fsm_count_monitor: RTL and testbench

- Reader-side checker for the enable-driven modulo-2^W state counter.
- Each cycle it samples the counter's enable and count output, predicts the next count, and locks once predictions hold.
- Once locked, it flags skips and stalls and counts wraps and errors.
- Sits beside the counter in lab top levels; its outputs drive LEDs or the seven-segment status.

---
 rtl/fsm_count_monitor.sv | 110 +++++++++++
 tb/tb_fsm_count_monitor.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/fsm_count_monitor.sv
// fsm_count_monitor: locks onto a modulo-2^W counter and flags skips/stalls.
// Optional FSM_MON_STICKY_EN holds FAULT until clr_err is sampled.
module fsm_count_monitor #(
  parameter int W        = 3,
  parameter int LOCK_CNT = 4,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [W-1:0]     num,
  input  logic             clr_err,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] wrap_cnt,
  output logic [W-1:0]     expected
);

  typedef enum logic [1:0] {
    SYNC,
    TRACK,
    LOCKED,
    FAULT
  } state_t;

  localparam logic [W-1:0]     NUM_ONE = 1;
  localparam logic [W-1:0]     NUM_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [3:0]       LAST    = 4'(LOCK_CNT - 1);

  state_t       state, state_nxt;
  logic [3:0]   mcnt, mcnt_nxt;
  logic         en_d;
  logic [W-1:0] num_d;
  logic         match;
  logic         err_inc;
  logic         wrap_inc;

  assign match  = (num == expected);
  assign locked = (state == LOCKED);
  assign err    = (state == LOCKED) && !match;

`ifndef FSM_MON_STICKY_EN
  logic unused_clr;
  assign unused_clr = clr_err;
`endif

  always_comb begin
    state_nxt = state;
    mcnt_nxt  = mcnt;
    err_inc   = 1'b0;
    wrap_inc  = 1'b0;
    unique case (state)
      SYNC: begin
        state_nxt = TRACK;
        mcnt_nxt  = '0;
      end
      TRACK: begin
        if (!match) begin
          state_nxt = SYNC;
        end else if (mcnt == LAST) begin
          state_nxt = LOCKED;
        end else begin
          mcnt_nxt = mcnt + 4'd1;
        end
      end
      LOCKED: begin
        if (!match) begin
          err_inc   = 1'b1;
          state_nxt = FAULT;
        end else if (en_d && num_d == NUM_MAX && num == '0) begin
          wrap_inc = 1'b1;
        end
      end
      FAULT: begin
`ifdef FSM_MON_STICKY_EN
        if (clr_err) state_nxt = SYNC;
`else
        state_nxt = SYNC;
`endif
      end
      default: state_nxt = SYNC;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= SYNC;
      mcnt     <= '0;
      en_d     <= 1'b0;
      num_d    <= '0;
      expected <= '0;
      err_cnt  <= '0;
      wrap_cnt <= '0;
    end else begin
      state    <= state_nxt;
      mcnt     <= mcnt_nxt;
      en_d     <= en;
      num_d    <= num;
      expected <= en ? num + NUM_ONE : num;
      if (err_inc && err_cnt != CNT_MAX)
        err_cnt <= err_cnt + CNT_ONE;
      if (wrap_inc && wrap_cnt != CNT_MAX)
        wrap_cnt <= wrap_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_fsm_count_monitor.sv
// tb_fsm_count_monitor: table vectors plus hand sequences for
// fault, saturation, relock and asynchronous reset.
module tb_fsm_count_monitor;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       en = 1'b0;
  logic [2:0] num = '0;
  logic       clr_err = 1'b0;
  logic       locked;
  logic       err;
  logic [7:0] err_cnt;
  logic [7:0] wrap_cnt;
  logic [2:0] expected;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       en;
    logic [2:0] num;
    logic       clr;
    logic       chk;
    logic       lk;
    logic       er;
    logic       cchk;
    logic [7:0] ec;
    logic [7:0] wc;
    logic [2:0] xp;
  } vec_t;

  vec_t       q[$];
  vec_t       tbl[26];
  logic       pen = 1'b0;
  logic [2:0] pnum = '0;
  logic [2:0] cur;

  fsm_count_monitor #(.W(3), .LOCK_CNT(4), .CNT_W(8)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .en(en),
    .num(num),
    .clr_err(clr_err),
    .locked(locked),
    .err(err),
    .err_cnt(err_cnt),
    .wrap_cnt(wrap_cnt),
    .expected(expected)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  function automatic vec_t mk(
    input logic e, input logic [2:0] n, input logic c,
    input logic k, input logic l, input logic r,
    input logic cc, input logic [7:0] ec, input logic [7:0] wc);
    vec_t v;
    v.en = e; v.num = n; v.clr = c; v.chk = k;
    v.lk = l; v.er = r; v.cchk = cc;
    v.ec = ec; v.wc = wc; v.xp = '0;
    return v;
  endfunction

  task automatic cmp(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t",
               nm, act, req, $time);
    end
  endtask

  task automatic step(input vec_t v);
    vec_t r;
    v.xp = pen ? 3'(pnum + 3'd1) : pnum;
    en = v.en;
    num = v.num;
    clr_err = v.clr;
    pen = v.en;
    pnum = v.num;
    q.push_back(v);
    @(negedge clk);
    if (q.size() == 0) begin
      cmp("queue_empty", 0, 1);
    end else begin
      r = q.pop_front();
      if (r.chk) begin
        cmp("locked", int'(locked), int'(r.lk));
        cmp("err", int'(err), int'(r.er));
        cmp("expected", int'(expected), int'(r.xp));
      end
      if (r.cchk) begin
        cmp("err_cnt", int'(err_cnt), int'(r.ec));
        cmp("wrap_cnt", int'(wrap_cnt), int'(r.wc));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic count(input logic l);
    step(mk(1, cur, 0, 1, l, 0, 0, 0, 0));
    cur = cur + 3'd1;
  endtask

  initial begin
    tbl[0]  = mk(1, 0, 0, 1, 0, 0, 1, 0, 0);
    tbl[1]  = mk(1, 1, 0, 1, 0, 0, 1, 0, 0);
    tbl[2]  = mk(1, 2, 0, 1, 0, 0, 1, 0, 0);
    tbl[3]  = mk(1, 3, 0, 1, 0, 0, 1, 0, 0);
    tbl[4]  = mk(1, 4, 0, 1, 0, 0, 1, 0, 0);
    tbl[5]  = mk(1, 5, 0, 1, 1, 0, 1, 0, 0);
    tbl[6]  = mk(1, 6, 0, 1, 1, 0, 1, 0, 0);
    tbl[7]  = mk(1, 7, 0, 1, 1, 0, 1, 0, 0);
    tbl[8]  = mk(1, 0, 0, 1, 1, 0, 1, 0, 0);
    tbl[9]  = mk(0, 1, 0, 1, 1, 0, 1, 0, 1);
    tbl[10] = mk(1, 1, 1, 1, 1, 0, 1, 0, 1);
    tbl[11] = mk(0, 2, 0, 1, 1, 0, 1, 0, 1);
    tbl[12] = mk(1, 2, 0, 1, 1, 0, 1, 0, 1);
    tbl[13] = mk(1, 3, 0, 1, 1, 0, 1, 0, 1);
    tbl[14] = mk(1, 5, 0, 1, 1, 1, 1, 0, 1);
    tbl[15] = mk(1, 6, 1, 1, 0, 0, 1, 1, 1);
    tbl[16] = mk(1, 7, 0, 1, 0, 0, 1, 1, 1);
    tbl[17] = mk(1, 0, 0, 1, 0, 0, 1, 1, 1);
    tbl[18] = mk(1, 1, 0, 1, 0, 0, 1, 1, 1);
    tbl[19] = mk(1, 2, 0, 1, 0, 0, 1, 1, 1);
    tbl[20] = mk(1, 3, 0, 1, 0, 0, 1, 1, 1);
    tbl[21] = mk(1, 4, 0, 1, 1, 0, 1, 1, 1);
    tbl[22] = mk(1, 5, 0, 1, 1, 0, 1, 1, 1);
    tbl[23] = mk(1, 6, 0, 1, 1, 0, 1, 1, 1);
    tbl[24] = mk(1, 6, 0, 1, 1, 1, 1, 1, 1);
    tbl[25] = mk(1, 7, 1, 1, 0, 0, 1, 2, 1);

    #3;
    cmp("rst_locked", int'(locked), 0);
    cmp("rst_err", int'(err), 0);
    cmp("rst_err_cnt", int'(err_cnt), 0);
    cmp("rst_wrap_cnt", int'(wrap_cnt), 0);
    cmp("rst_expected", int'(expected), 0);

    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 26; i++) step(tbl[i]);

    cur = 3'd0;
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < 5; k++) count(1'b0);
      step(mk(1, cur - 3'd1, 0, 1, 1, 1, 0, 0, 0));
      step(mk(1, cur, 1, 1, 0, 0, 0, 0, 0));
      cur = cur + 3'd1;
    end

    for (int k = 0; k < 5; k++) count(1'b0);
    step(mk(1, cur, 0, 1, 1, 0, 1, 8'd255, 1));
    cur = cur + 3'd1;
    step(mk(0, cur, 0, 1, 1, 0, 0, 0, 0));
    step(mk(1, cur + 3'd1, 0, 1, 1, 1, 1, 8'd255, 1));
    cur = cur + 3'd2;
    step(mk(1, cur, 0, 1, 0, 0, 1, 8'd255, 1));
    cur = cur + 3'd1;
`ifdef FSM_MON_STICKY_EN
    for (int k = 0; k < 20; k++) count(1'b0);
    step(mk(1, cur, 1, 1, 0, 0, 0, 0, 0));
    cur = cur + 3'd1;
`endif
    for (int k = 0; k < 5; k++) count(1'b0);
    step(mk(1, cur, 0, 1, 1, 0, 1, 8'd255, 1));
    cur = cur + 3'd1;

    #2;
    reset_n = 1'b0;
    #1;
    cmp("mid_rst_locked", int'(locked), 0);
    cmp("mid_rst_err", int'(err), 0);
    cmp("mid_rst_err_cnt", int'(err_cnt), 0);
    cmp("mid_rst_wrap_cnt", int'(wrap_cnt), 0);
    cmp("mid_rst_expected", int'(expected), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
